mole_hit_judge: RTL
===================

# mole_hit_judge

Event source for the combo scoring logic: tracks which moles are raised, times each one out, and classifies debounced button presses. Emits the single-cycle `miss`, `non_full_clear_hit` and `full_clear_hit` pulses that the combo counter consumes. Sits between the mole spawner/button edge detectors and the scoring blocks.

## Interface
- `NUM_MOLES`, 8, number of mole positions / buttons (2..16)
- `TIMER_W`, 27, width of per-mole lifetime counter (cycles of `clk`)
- `clk` input 1, DE2-115 50 MHz clock; the block's only clock
- `reset_n` input 1, asynchronous, active-low; clears all state
- `game_active` input 1, HIGH while a round is running
- `spawn_valid` input 1, request to raise mole `spawn_idx` this cycle
- `spawn_idx` input $clog2(NUM_MOLES), index of mole to raise
- `mole_life` input TIMER_W, lifetime in cycles, sampled with `spawn_valid`
- `btn_press` input NUM_MOLES, one-cycle press pulses (already debounced/edge-detected)
- `moles_up` output NUM_MOLES, current board; bit i HIGH = mole i raised
- `miss` output 1, one-cycle pulse: mole timed out or empty hole pressed
- `non_full_clear_hit` output 1, one-cycle pulse: hit(s), board not emptied
- `full_clear_hit` output 1, one-cycle pulse: hit(s) emptied the board

## Operation
- Reset (`reset_n` LOW, any time, async): `moles_up`=0, all timers=0, all three pulses=0.
- `game_active` LOW: board and timers cleared at next edge, pulses forced 0, spawns and presses ignored. No miss on round end.
- Per cycle, judgement uses the board state B at the start of the cycle:
  - hit set H = `btn_press` & B; wrong set W = `btn_press` & ~B.
  - expiry set E = moles in B with timer==1 and not in H (press in final up cycle counts as hit).
  - miss event if W or E non-empty. Moles in H and E are cleared regardless.
  - Priority: miss event -> only `miss` pulses (hits still clear moles, no hit pulse).
  - Else H non-empty and (B & ~H)==0 -> `full_clear_hit`.
  - Else H non-empty -> `non_full_clear_hit`.
  - Multiple hits in one cycle produce one pulse, not one per mole.
  - At most one output pulse HIGH in any cycle.
- Spawn: accepted only if mole `spawn_idx` is down in B; otherwise dropped silently. Out-of-range index dropped. Spawn onto a mole in H is dropped (mole was up in B). Full-clear is judged on B, independent of same-cycle spawn.
- Timer: accepted spawn loads `max(mole_life,1)`; each edge an up mole decrements; mole drops at the edge its timer goes 1->0.

## Timing
- All outputs registered; update on rising `clk`.
- Press sampled at edge t -> pulse HIGH for exactly one cycle after edge t; `moles_up` bit clears at same edge t.
- Spawn sampled at edge t with `mole_life`=L -> `moles_up` bit HIGH for exactly L cycles (edges t..t+L-1 later), drops at edge t+L with `miss` HIGH in the following cycle, unless hit earlier.
- No handshake/back-pressure; consumer must accept pulses every cycle.
- `reset_n` deassertion is synchronised externally; first judged edge is the first after release.

## Structure
- Shared package `mole_pkg`: `NUM_MOLES`, `TIMER_W`, `MOLE_IDX_W` = $clog2(NUM_MOLES), default lifetime constants for difficulty levels.
- Sub-module `mole_timer` (one per position, generated): load/decrement/clear, outputs `up` and `expiring` (timer==1). Top level holds judgement logic and output registers.

## Test plan
- Spawn idx 3, life 10, no press -> `moles_up`=0x08 for 10 cycles, then 0x00 and single `miss` pulse.
- Moles 1,2 up; press btn 1 -> `non_full_clear_hit` one cycle, `moles_up`=0x04; press btn 2 -> `full_clear_hit`, `moles_up`=0x00.
- Board empty, press btn 5 -> `miss` one cycle, board unchanged.
- Mole 0 up, press btn 0 and btn 4 same cycle -> `miss` only, mole 0 cleared.
- Mole 2 life 4, press btn 2 in its 4th up cycle -> `full_clear_hit`, no `miss`; spawn idx 2 while up -> ignored, timer unchanged.
- Moles 0,1,6 up, assert `reset_n` LOW mid-round -> all outputs 0 immediately; `game_active` falling -> board cleared, no `miss`.

Source files
------------

// File: rtl/mole_pkg.sv
// mole_pkg: shared sizing and default mole lifetimes for the whack-a-mole judge.
package mole_pkg;
   localparam int NUM_MOLES  = 8;
   localparam int TIMER_W    = 27;
   localparam int MOLE_IDX_W = $clog2(NUM_MOLES);
   typedef enum logic [1:0] {DIFF_EASY, DIFF_NORMAL, DIFF_HARD} difficulty_t;
   // lifetimes in 50 MHz cycles: 1.5 s, 1.0 s, 0.5 s
   localparam logic [TIMER_W-1:0] LIFE_EASY   = 27'd75_000_000;
   localparam logic [TIMER_W-1:0] LIFE_NORMAL = 27'd50_000_000;
   localparam logic [TIMER_W-1:0] LIFE_HARD   = 27'd25_000_000;
   function automatic logic [TIMER_W-1:0] default_life(difficulty_t d);
      return d == DIFF_HARD ? LIFE_HARD : d == DIFF_NORMAL ? LIFE_NORMAL : LIFE_EASY;
   endfunction
endpackage

// File: rtl/mole_hit_judge_if.sv
// mole_hit_judge_if: spawner/button side and scoring-event side of the hit judge.
interface mole_hit_judge_if;
   import mole_pkg::*;
   logic                  game_active;
   logic                  spawn_valid;
   logic [MOLE_IDX_W-1:0] spawn_idx;
   logic [TIMER_W-1:0]    mole_life;
   logic [NUM_MOLES-1:0]  btn_press;
   logic [NUM_MOLES-1:0]  moles_up;
   logic                  miss;
   logic                  non_full_clear_hit;
   logic                  full_clear_hit;
   modport master (
      output game_active, spawn_valid, spawn_idx, mole_life, btn_press,
      input  moles_up, miss, non_full_clear_hit, full_clear_hit
   );
   modport slave (
      input  game_active, spawn_valid, spawn_idx, mole_life, btn_press,
      output moles_up, miss, non_full_clear_hit, full_clear_hit
   );
endinterface

// File: rtl/mole_timer.sv
// mole_timer: lifetime counter for one mole position; the mole is up while the count is nonzero.
module mole_timer
   import mole_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               game_active,
   input  logic               clr,
   input  logic               load,
   input  logic [TIMER_W-1:0] life,
   output logic               up,
   output logic               expiring
);
   logic [TIMER_W-1:0] cnt;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (!game_active || clr) cnt <= '0;
      else if (load) cnt <= (life == '0) ? TIMER_W'(1) : life;
      else if (up) cnt <= cnt - 1'b1;
   assign up       = cnt != '0;
   assign expiring = cnt == TIMER_W'(1);
endmodule

// File: rtl/mole_hit_judge.sv
// mole_hit_judge: tracks raised moles, times them out and turns presses into miss/hit pulses.
module mole_hit_judge
   import mole_pkg::*;
(
   input logic              clk,
   input logic              reset_n,
   mole_hit_judge_if.slave  bus
);
   logic [NUM_MOLES-1:0] board, expiring, hit, wrong, expired, load, left;
   logic                 miss_ev, any_hit, miss_q, nfc_q, fc_q;
   assign hit     = bus.btn_press & board;
   assign wrong   = bus.btn_press & ~board;
   assign expired = expiring & ~hit;
   assign left    = board & ~hit;
   assign miss_ev = |wrong || |expired;
   assign any_hit = |hit;
   // a spawn only lands on a hole that is empty at the start of the cycle
   assign load    = bus.spawn_valid ? (NUM_MOLES'(1) << bus.spawn_idx) & ~board : '0;
   for (genvar i = 0; i < NUM_MOLES; i++) begin : g_timer
      mole_timer u_timer (
         .clk         (clk),
         .reset_n     (reset_n),
         .game_active (bus.game_active),
         .clr         (hit[i]),
         .load        (load[i]),
         .life        (bus.mole_life),
         .up          (board[i]),
         .expiring    (expiring[i])
      );
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         miss_q <= 1'b0;
         nfc_q  <= 1'b0;
         fc_q   <= 1'b0;
      end else begin
         miss_q <= bus.game_active && miss_ev;
         nfc_q  <= bus.game_active && !miss_ev && any_hit && |left;
         fc_q   <= bus.game_active && !miss_ev && any_hit && !(|left);
      end
   assign bus.moles_up           = board;
   assign bus.miss               = miss_q;
   assign bus.non_full_clear_hit = nfc_q;
   assign bus.full_clear_hit     = fc_q;
endmodule
